// File: rtl/reg_stack_pkg.sv
// Shared definitions for the LIFO register stack: {push,pop} op encoding and count sizing.
package reg_stack_pkg;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_PUSH = 2'b10;
   localparam logic [1:0] OP_REPL = 2'b11;

   // Count must represent 0..DEPTH inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/word_reg.sv
// Load-enabled storage word with no reset; contents are qualified by the stack count.
module word_reg #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (load) q <= d;
   end

endmodule

// File: rtl/reg_stack.sv
// LIFO register stack with push/pop/replace, registered top-of-stack and sticky error flag.
module reg_stack
   import reg_stack_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          in,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      clr,
   output logic [WIDTH-1:0]          out,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      empty,
   output logic                      full,
   output logic                      err
);

   localparam int unsigned CW = cnt_w(DEPTH);
   localparam int unsigned IW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] load;
   logic             we;
   logic [IW-1:0]    widx;
   logic [IW-1:0]    ridx;
   logic [WIDTH-1:0] rd_data;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             err_nxt;
   logic [1:0]       op;

   assign op    = {push, pop};
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
      word_reg #(.WIDTH(WIDTH)) u_word (
         .clk  (clk),
         .load (load[i]),
         .d    (in),
         .q    (mem[i])
      );
   end

   // One-hot write decode of the write index.
   always_comb begin
      load = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (we && (widx == IW'(i))) load[i] = 1'b1;
      end
   end

   // Entry just below the top becomes the new top on a pop.
   always_comb begin
      ridx    = IW'(count - CW'(2));
      rd_data = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (ridx == IW'(i)) rd_data = mem[i];
      end
   end

   always_comb begin
      count_nxt = count;
      out_nxt   = out;
      err_nxt   = err;
      we        = 1'b0;
      widx      = IW'(count);
      if (clr) begin
         count_nxt = '0;
         out_nxt   = '0;
         err_nxt   = 1'b0;
      end else begin
         case (op)
            OP_PUSH: begin
               if (full) begin
                  err_nxt = 1'b1;
               end else begin
                  we        = 1'b1;
                  count_nxt = count + CW'(1);
                  out_nxt   = in;
               end
            end
            OP_POP: begin
               if (empty) begin
                  err_nxt = 1'b1;
               end else if (count == CW'(1)) begin
                  count_nxt = '0;
                  out_nxt   = '0;
               end else begin
                  count_nxt = count - CW'(1);
                  out_nxt   = rd_data;
               end
            end
            OP_REPL: begin
               we      = 1'b1;
               out_nxt = in;
               if (empty) begin
                  count_nxt = CW'(1);
               end else begin
                  widx = IW'(count - CW'(1));
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         out   <= '0;
         err   <= 1'b0;
      end else begin
         count <= count_nxt;
         out   <= out_nxt;
         err   <= err_nxt;
      end
   end

endmodule
